pipe_stall_ctrl: RTL

//  Pipeline sequencer for the 5-stage core. Produces the per-stage stall vector and flush

---
 rtl/pipe_stall_ctrl_pkg.sv | 14 +
 rtl/pipe_stall_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_stall_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_stall_ctrl_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam logic [5:0] STALL_NONE     = 6'b000000;
  localparam logic [5:0] STALL_MULTI    = 6'b001111;
  localparam logic [5:0] STALL_LOAD_USE = 6'b000111;

  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_BUSY = 2'd1;
  localparam logic [1:0] MC_DONE = 2'd2;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID source reads and a load sitting in EX.
module hazard_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic      id_rs_read,
  input  logic      id_rt_read,
  input  reg_addr_t id_rs_addr,
  input  reg_addr_t id_rt_addr,
  input  logic      ex_is_load,
  input  logic      ex_we,
  input  reg_addr_t ex_w_addr,
  output logic      hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_rs_read && (id_rs_addr == ex_w_addr);
  assign rt_match = id_rt_read && (id_rt_addr == ex_w_addr);

  // $0 is hardwired to zero, so a load "into" it never produces data to wait for.
  assign hazard = ex_is_load && ex_we && (ex_w_addr != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: per-stage stall vector, flush pulse, multi-cycle EX timing
// and a saturating stall-cycle performance counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 6,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_rs_read,
  input  logic              id_rt_read,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic              ex_is_load,
  input  logic              ex_we,
  input  logic [4:0]        ex_w_addr,
  input  logic              ex_mc_start,
  input  logic              flush_req,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [PERF_W-1:0] perf_stall_cyc
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .id_rs_read (id_rs_read),
    .id_rt_read (id_rt_read),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .ex_is_load (ex_is_load),
    .ex_we      (ex_we),
    .ex_w_addr  (ex_w_addr),
    .hazard     (load_use)
  );

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_req) begin
      state_d = MC_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MC_IDLE: if (ex_mc_start) begin
          state_d = MC_BUSY;
          cnt_d   = CNT_W'(MC_CYCLES - 2);
        end
        MC_BUSY: begin
          // Leave BUSY as the count reaches zero, so the op occupies MC_CYCLES cycles
          // including the accepting IDLE cycle and the DONE cycle.
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = MC_DONE;
        end
        MC_DONE: state_d = MC_IDLE;
        default: state_d = MC_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = STALL_NONE;
    flush = 1'b0;
    if (!rst) begin
      stall = STALL_NONE;
    end else if (flush_req) begin
      flush = 1'b1;
    end else if ((state_q == MC_IDLE && ex_mc_start) || state_q == MC_BUSY) begin
      stall = STALL_MULTI;
    end else if (load_use) begin
      stall = STALL_LOAD_USE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= MC_IDLE;
      cnt_q          <= '0;
      mc_busy        <= 1'b0;
      mc_done        <= 1'b0;
      perf_stall_cyc <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_busy <= (state_d == MC_BUSY);
      mc_done <= (state_d == MC_DONE);
      if (stall != STALL_NONE && perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + PERF_W'(1);
    end
  end

endmodule
